// File: rtl/frame_sequencer.sv
// Frame controller: trigger generation (period timer or external swap),
// framebuffer switch/clear pulses, fetch-reset / view-matrix sequencing
// around framebuffer readiness, and per-frame pixel / frame / drop stats.
module frame_sequencer #(
  parameter int PERIOD      = 2_000_000,
  parameter int TIMER_WIDTH = 22,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   mode_in,
  input  logic                   swap_req_in,
  input  logic                   fb_ready_in,
  input  logic                   pixel_valid_in,
  input  logic                   pipe_idle_in,
  output logic                   fetch_rst_out,
  output logic                   matrix_start_out,
  output logic                   fb_switch_out,
  output logic                   fb_clear_out,
  output logic [COUNT_WIDTH-1:0] frame_count_out,
  output logic [COUNT_WIDTH-1:0] pixel_count_out,
  output logic [COUNT_WIDTH-1:0] last_pixel_count_out,
  output logic [COUNT_WIDTH-1:0] drop_count_out
);

  typedef enum logic [1:0] {WAIT_BUF, START, RENDER} state_t;

  localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(PERIOD - 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE    = COUNT_WIDTH'(1);

  state_t                 state;
  logic [TIMER_WIDTH-1:0] timer;
  logic                   trig;
  logic [COUNT_WIDTH-1:0] pix_next;

  // External mode ignores the timer entirely; timer mode fires on the last tick.
  assign trig = mode_in ? swap_req_in : (timer == TIMER_LAST);

  // Pixel count including this cycle's pixel, pinned at all-ones.
  always_comb begin
    pix_next = pixel_count_out;
    if (pixel_valid_in && (pixel_count_out != '1))
      pix_next = pixel_count_out + CNT_ONE;
  end

  // Period timer; held at 0 in external mode, so a mode change restarts it.
  always_ff @(posedge clk_in) begin
    if (rst_in)
      timer <= '0;
    else if (mode_in || (timer == TIMER_LAST))
      timer <= '0;
    else
      timer <= timer + TIMER_WIDTH'(1);
  end

  // Swap/clear pulses and tear detection, independent of the frame FSM.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      fb_switch_out  <= 1'b0;
      fb_clear_out   <= 1'b1;
      drop_count_out <= '0;
    end else begin
      fb_switch_out <= trig;
      fb_clear_out  <= trig;
      if (trig && (state == RENDER) && !pipe_idle_in)
        drop_count_out <= drop_count_out + CNT_ONE;
    end
  end

  // Frame FSM: outputs are set on the transition so they line up with the state.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state                <= WAIT_BUF;
      fetch_rst_out        <= 1'b1;
      matrix_start_out     <= 1'b0;
      frame_count_out      <= '0;
      pixel_count_out      <= '0;
      last_pixel_count_out <= '0;
    end else begin
      matrix_start_out <= 1'b0;
      case (state)
        WAIT_BUF: begin
          fetch_rst_out <= 1'b1;
          if (fb_ready_in) begin
            state            <= START;
            matrix_start_out <= 1'b1;
            frame_count_out  <= frame_count_out + CNT_ONE;
            pixel_count_out  <= '0;
          end
        end
        START: begin
          fetch_rst_out <= 1'b0;
          state         <= RENDER;
        end
        RENDER: begin
          pixel_count_out <= pix_next;
          if (!fb_ready_in) begin
            last_pixel_count_out <= pix_next;
            fetch_rst_out        <= 1'b1;
            state                <= WAIT_BUF;
          end
        end
        default: begin
          state         <= WAIT_BUF;
          fetch_rst_out <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer: directed stimulus, cycle model compared every
// cycle, plus literal expectations at the points of interest.
module tb_frame_sequencer;
  localparam int PERIOD = 10;
  localparam int CW     = 16;
  localparam int CMAX   = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst, mode, swap, ready, pv, idle;
  logic fetch_rst, mstart, fb_sw, fb_clr;
  logic [CW-1:0] frames, pix, last_pix, drops;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pulses[$];

  frame_sequencer #(.PERIOD(PERIOD), .TIMER_WIDTH(4), .COUNT_WIDTH(CW)) dut (
    .clk_in(clk), .rst_in(rst), .mode_in(mode), .swap_req_in(swap),
    .fb_ready_in(ready), .pixel_valid_in(pv), .pipe_idle_in(idle),
    .fetch_rst_out(fetch_rst), .matrix_start_out(mstart),
    .fb_switch_out(fb_sw), .fb_clear_out(fb_clr),
    .frame_count_out(frames), .pixel_count_out(pix),
    .last_pixel_count_out(last_pix), .drop_count_out(drops)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 30) $display("FAIL %s: got %0d want %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: frame phase 0 = waiting, 1 = start, 2 = rendering.
  int m_phase = 0, m_timer = 0;
  int m_fetch = 1, m_ms = 0, m_sw = 0, m_clr = 1;
  int m_frames = 0, m_pix = 0, m_last = 0, m_drops = 0;

  task automatic model_step();
    bit trig;
    int ph;
    if (rst) begin
      m_phase = 0; m_timer = 0; m_fetch = 1; m_ms = 0; m_sw = 0; m_clr = 1;
      m_frames = 0; m_pix = 0; m_last = 0; m_drops = 0;
      return;
    end
    ph   = m_phase;
    trig = mode ? swap : (m_timer == PERIOD - 1);
    m_sw = trig; m_clr = trig;
    if (trig && ph == 2 && !idle) m_drops = (m_drops + 1) % (CMAX + 1);
    m_timer = mode ? 0 : (m_timer + 1) % PERIOD;
    m_ms = 0;
    if (ph == 0 && ready) begin
      m_phase = 1; m_ms = 1; m_frames = (m_frames + 1) % (CMAX + 1); m_pix = 0;
    end else if (ph == 1) begin
      m_phase = 2; m_fetch = 0;
    end else if (ph == 2) begin
      if (pv && m_pix < CMAX) m_pix++;
      if (!ready) begin m_last = m_pix; m_fetch = 1; m_phase = 0; end
    end
  endtask

  // Step the model on each edge, then compare just after the edge.
  always @(posedge clk) begin
    cyc = rst ? 0 : cyc + 1;
    model_step();
    #1;
    check("fetch_rst", fetch_rst, m_fetch);
    check("matrix_start", mstart, m_ms);
    check("fb_switch", fb_sw, m_sw);
    check("fb_clear", fb_clr, m_clr);
    check("frame_count", frames, m_frames);
    check("pixel_count", pix, m_pix);
    check("last_pixel_count", last_pix, m_last);
    check("drop_count", drops, m_drops);
  end

  always @(negedge clk) if (!rst && fb_sw) pulses.push_back(cyc);

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    int stray;
    rst = 1; mode = 0; swap = 0; ready = 0; pv = 0; idle = 1;
    repeat (3) @(negedge clk);
    check("rst fetch_rst", fetch_rst, 1);
    check("rst fb_clear", fb_clr, 1);
    check("rst fb_switch", fb_sw, 0);
    check("rst frames", frames, 0);
    rst = 0;

    // 1: frame start and timer pulses
    wait_to(3);  ready = 1;
    wait_to(4);  check("start mstart", mstart, 1); check("start frames", frames, 1);
    wait_to(5);  check("mstart once", mstart, 0); check("fetch released", fetch_rst, 0);
    // 2: 7 pixels, then an 8th on the cycle the buffer goes away
    pv = 1;
    wait_to(12); ready = 0;
    wait_to(13); pv = 0;
    check("last_pix 8", last_pix, 8); check("fetch back", fetch_rst, 1);
    wait_to(35);
    check("timer pulse count", pulses.size(), 3);
    if (pulses.size() >= 3) begin
      check("pulse0", pulses[0], 10); check("pulse1", pulses[1], 20); check("pulse2", pulses[2], 30);
    end
    // 3: external mode, back-to-back swaps
    wait_to(45); mode = 1;
    wait_to(50); swap = 1;
    wait_to(51); check("swap pulse 51", fb_sw, 1); check("clear 51", fb_clr, 1);
    wait_to(52); swap = 0; check("swap pulse 52", fb_sw, 1);
    wait_to(53); check("swap done 53", fb_sw, 0);
    // 4: drop detection
    wait_to(60); ready = 1;
    wait_to(64);
    stray = 0;
    foreach (pulses[i]) if (pulses[i] > 40 && pulses[i] != 51 && pulses[i] != 52) stray++;
    check("no timer pulses in mode 1", stray, 0);
    idle = 0; swap = 1;
    wait_to(65); swap = 0; check("drop 1", drops, 1);
    wait_to(66); idle = 1; swap = 1;
    wait_to(67); swap = 0; check("drop idle", drops, 1); check("swap while idle", fb_sw, 1);
    // 5: saturation
    wait_to(70); pv = 1;
    wait_to(70 + 65534); check("pix FFFE", pix, 16'hFFFE);
    wait_to(70 + 65537); check("pix sat", pix, 16'hFFFF);
    wait_to(70 + 65539); pv = 0; check("pix hold", pix, 16'hFFFF);
    check("last before rst", last_pix, 8);
    // 6: reset mid-frame
    rst = 1;
    @(negedge clk);
    check("mid rst frames", frames, 0); check("mid rst pix", pix, 0);
    check("mid rst last", last_pix, 0); check("mid rst drops", drops, 0);
    check("mid rst fetch", fetch_rst, 1); check("mid rst clear", fb_clr, 1);
    rst = 0; ready = 0;
    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
